// File: rtl/bus_sram_responder_if.sv
// Bus bundle between an initiator and the SRAM responder.
// master drives requests and write data; slave returns read data, end and error.
interface bus_sram_responder_if;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [7:0]  burstSizeIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  modport master (
    output beginTransactionIn,
    output addressDataIn,
    output readNotWriteIn,
    output burstSizeIn,
    output byteEnablesIn,
    output dataValidIn,
    output endTransactionIn,
    input  addressDataOut,
    input  dataValidOut,
    input  endTransactionOut,
    input  busErrorOut
  );

  modport slave (
    input  beginTransactionIn,
    input  addressDataIn,
    input  readNotWriteIn,
    input  burstSizeIn,
    input  byteEnablesIn,
    input  dataValidIn,
    input  endTransactionIn,
    output addressDataOut,
    output dataValidOut,
    output endTransactionOut,
    output busErrorOut
  );
endinterface

// File: rtl/bus_sram_responder.sv
// Burst SRAM responder on a shared wired-OR bus; window of 2^ADDR_WIDTH words.
// Ports: clock, reset (async, active-low), bus (slave modport of bus_sram_responder_if).
module bus_sram_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_sram_responder_if.slave   bus
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_END,
    S_ERROR
  } state_t;

  logic [31:0] mem [WORDS];

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic [2:0]            lat_q;
  logic                  ovr_q;
  logic [31:0]           rdata_q;
  logic                  dv_q;
  logic                  eo_q;
  logic                  berr_q;

  logic                  sel;
  logic                  bad;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           span;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  wr_en;

  assign sel = bus.beginTransactionIn &&
    (bus.addressDataIn[31:ADDR_WIDTH+2] ==
     BASE_ADDR[31:ADDR_WIDTH+2]);

  assign waddr = bus.addressDataIn[ADDR_WIDTH+1:2];

  // Last word touched by the burst must stay inside the window.
  assign span = 32'(waddr) + 32'(bus.burstSizeIn);
  assign bad  = (bus.addressDataIn[1:0] != 2'b00) ||
                (span > 32'(WORDS - 1));

  assign addr_d = addr_q + 1'b1;

  // cnt_q holds the words still allowed; zero means overrun.
  assign wr_en = (state_q == S_WRITE) && bus.dataValidIn &&
                 (cnt_q != 9'd0);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteEnablesIn[b]) begin
          mem[addr_q][8*b +: 8] <= bus.addressDataIn[8*b +: 8];
        end
      end
    end
  end

  // Outputs default to 0 every cycle so they only pulse while driven.
  // During a read, cnt_q holds words still to issue after the current one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
      dv_q    <= 1'b0;
      eo_q    <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      rdata_q <= '0;
      dv_q    <= 1'b0;
      eo_q    <= 1'b0;
      berr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (sel) begin
            addr_q <= waddr;
            cnt_q  <= {1'b0, bus.burstSizeIn};
            lat_q  <= 3'(READ_LATENCY - 1);
            ovr_q  <= 1'b0;
            if (bad) begin
              state_q <= S_ERROR;
              berr_q  <= 1'b1;
              eo_q    <= 1'b1;
            end else if (bus.readNotWriteIn) begin
              state_q <= S_WAIT;
            end else begin
              state_q <= S_WRITE;
              cnt_q   <= {1'b0, bus.burstSizeIn} + 9'd1;
            end
          end
        end
        S_WAIT: begin
          if (bus.endTransactionIn) begin
            state_q <= S_IDLE;
          end else if (lat_q == 3'd0) begin
            rdata_q <= mem[addr_q];
            dv_q    <= 1'b1;
            addr_q  <= addr_d;
            state_q <= S_READ;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_READ: begin
          if (bus.endTransactionIn) begin
            state_q <= S_IDLE;
          end else if (cnt_q != 9'd0) begin
            rdata_q <= mem[addr_q];
            dv_q    <= 1'b1;
            addr_q  <= addr_d;
            cnt_q   <= cnt_q - 9'd1;
          end else begin
            eo_q    <= 1'b1;
            state_q <= S_END;
          end
        end
        S_WRITE: begin
          if (bus.dataValidIn) begin
            if (cnt_q != 9'd0) begin
              addr_q <= addr_d;
              cnt_q  <= cnt_q - 9'd1;
            end else if (!ovr_q) begin
              berr_q <= 1'b1;
              ovr_q  <= 1'b1;
            end
          end
          if (bus.endTransactionIn) begin
            state_q <= S_IDLE;
          end
        end
        S_END:   state_q <= S_IDLE;
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.addressDataOut    = rdata_q;
  assign bus.dataValidOut      = dv_q;
  assign bus.endTransactionOut = eo_q;
  assign bus.busErrorOut       = berr_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder.
// Flags word: bit2 busErrorOut, bit1 endTransactionOut, bit0 dataValidOut.
module tb_bus_sram_responder;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q [$];

  bus_sram_responder_if bus ();

  bus_sram_responder #(
    .BASE_ADDR    (BASE),
    .ADDR_WIDTH   (10),
    .READ_LATENCY (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] flags();
    return {29'b0, bus.busErrorOut, bus.endTransactionOut, bus.dataValidOut};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.beginTransactionIn = 1'b0;
    bus.addressDataIn      = '0;
    bus.readNotWriteIn     = 1'b0;
    bus.burstSizeIn        = '0;
    bus.byteEnablesIn      = '0;
    bus.dataValidIn        = 1'b0;
    bus.endTransactionIn   = 1'b0;
  endtask

  task automatic begin_tx(input logic [31:0] a, input logic rnw,
                          input logic [7:0] n);
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = a;
    bus.readNotWriteIn     = rnw;
    bus.burstSizeIn        = n;
    step();
    idle_in();
  endtask

  task automatic wr_word(input logic [31:0] d, input logic [3:0] be,
                         input logic last);
    bus.dataValidIn      = 1'b1;
    bus.addressDataIn    = d;
    bus.byteEnablesIn    = be;
    bus.endTransactionIn = last;
    step();
    idle_in();
  endtask

  task automatic rd_burst(input string tag, input logic [31:0] a);
    begin_tx(a, 1'b1, 8'(exp_q.size() - 1));
    chk({tag, "_wait"}, flags(), 32'h0);
    for (int i = 0; i < exp_q.size(); i++) begin
      step();
      chk({tag, "_dv"}, flags(), 32'h1);
      chk({tag, "_data"}, bus.addressDataOut, exp_q[i]);
    end
    step();
    chk({tag, "_end"}, flags(), 32'h2);
    chk({tag, "_end_data"}, bus.addressDataOut, 32'h0);
    step();
    chk({tag, "_idle"}, flags(), 32'h0);
    exp_q.delete();
  endtask

  task automatic err_tx(input string tag, input logic [31:0] a,
                        input logic [7:0] n);
    begin_tx(a, 1'b1, n);
    chk({tag, "_pulse"}, flags(), 32'h6);
    step();
    chk({tag, "_after"}, flags(), 32'h0);
  endtask

  initial begin
    idle_in();
    step();
    step();
    chk("reset_flags", flags(), 32'h0);
    chk("reset_data", bus.addressDataOut, 32'h0);
    reset = 1'b1;
    step();

    // Write burst then read it back.
    begin_tx(BASE + 32'h10, 1'b0, 8'd3);
    chk("wr_start", flags(), 32'h0);
    wr_word(32'h11, 4'hF, 1'b0);
    wr_word(32'h22, 4'hF, 1'b0);
    wr_word(32'h33, 4'hF, 1'b0);
    wr_word(32'h44, 4'hF, 1'b1);
    chk("wr_done", flags(), 32'h0);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    rd_burst("rd4", BASE + 32'h10);

    // Begin while busy is ignored.
    begin_tx(BASE + 32'h10, 1'b1, 8'd1);
    step();
    chk("busy_w0", bus.addressDataOut, 32'h11);
    bus.beginTransactionIn = 1'b1;
    bus.addressDataIn      = BASE + 32'h2;
    step();
    idle_in();
    chk("busy_w1", bus.addressDataOut, 32'h22);
    chk("busy_w1_flags", flags(), 32'h1);
    step();
    chk("busy_end", flags(), 32'h2);
    step();

    // Byte enables.
    begin_tx(BASE + 32'h40, 1'b0, 8'd0);
    wr_word(32'h1122_3344, 4'hF, 1'b1);
    begin_tx(BASE + 32'h40, 1'b0, 8'd0);
    wr_word(32'hAABB_CCDD, 4'b0101, 1'b1);
    exp_q = '{32'h11BB_33DD};
    rd_burst("be", BASE + 32'h40);

    // Outside window.
    begin_tx(BASE + 32'h1000, 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      chk("unsel_flags", flags(), 32'h0);
      chk("unsel_data", bus.addressDataOut, 32'h0);
      step();
    end

    // Misaligned and out-of-range bursts.
    err_tx("misalign", BASE + 32'h2, 8'd0);
    err_tx("range", BASE + 32'hFFC, 8'd1);

    // Overrun write.
    begin_tx(BASE + 32'h88, 1'b0, 8'd0);
    wr_word(32'h5555_5555, 4'hF, 1'b1);
    begin_tx(BASE + 32'h80, 1'b0, 8'd1);
    wr_word(32'hA1A1_A1A1, 4'hF, 1'b0);
    chk("ovr_w1", flags(), 32'h0);
    wr_word(32'hA2A2_A2A2, 4'hF, 1'b0);
    chk("ovr_w2", flags(), 32'h0);
    wr_word(32'hA3A3_A3A3, 4'hF, 1'b1);
    chk("ovr_err", flags(), 32'h4);
    step();
    chk("ovr_once", flags(), 32'h0);
    exp_q = '{32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'h5555_5555};
    rd_burst("ovr_rd", BASE + 32'h80);

    // Abort on second word of a burst-7 read.
    begin_tx(BASE + 32'hC0, 1'b1, 8'd7);
    step();
    chk("abort_w0", flags(), 32'h1);
    step();
    chk("abort_w1", flags(), 32'h1);
    bus.endTransactionIn = 1'b1;
    step();
    idle_in();
    chk("abort_next", flags(), 32'h0);
    chk("abort_data", bus.addressDataOut, 32'h0);
    step();
    chk("abort_idle", flags(), 32'h0);
    exp_q = '{32'h11};
    rd_burst("post_abort", BASE + 32'h10);

    // Reset mid-burst.
    begin_tx(BASE + 32'h10, 1'b1, 8'd3);
    step();
    chk("rst_w0", bus.addressDataOut, 32'h11);
    reset = 1'b0;
    #1;
    chk("rst_async_flags", flags(), 32'h0);
    chk("rst_async_data", bus.addressDataOut, 32'h0);
    step();
    #2;
    reset = 1'b1;
    step();
    chk("rst_hold", flags(), 32'h0);
    exp_q = '{32'h22, 32'h33};
    rd_burst("post_rst", BASE + 32'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
